// File: rtl/triangle_sweep_ctrl_pkg.sv
// Shared types and constants for the triangle generator sweep sequencer.
package triangle_sweep_ctrl_pkg;

  localparam int unsigned LUT_ADDR_W = 10;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Undefined mode code 3 behaves as fixed frequency.
  function automatic logic [1:0] sanitize_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_FIXED : m;
  endfunction

endpackage

// File: rtl/triangle_sweep_ctrl_sweep_step_gen.sv
// Phase-step generator: shadow sweep config, dwell counter and step update with saturate/reload.
module sweep_step_gen
  import triangle_sweep_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_start,
  input  logic [PHASE_W-1:0] cfg_stop,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               init,
  input  logic               advance,
  output logic [PHASE_W-1:0] step
);

  logic [1:0]         sh_mode;
  logic [PHASE_W-1:0] sh_start;
  logic [PHASE_W-1:0] sh_stop;
  logic [PHASE_W-1:0] sh_delta;
  logic [DWELL_W-1:0] sh_dwell;
  logic [DWELL_W-1:0] dwell_cnt;

  logic [DWELL_W-1:0] dwell_last;
  logic               dwell_end;
  logic [PHASE_W:0]   nxt;
  logic               past_stop;

  // A zero dwell behaves like a dwell of one sample.
  always_comb begin
    dwell_last = '0;
    if (sh_dwell != '0) dwell_last = sh_dwell - DWELL_W'(1);
    dwell_end = (dwell_cnt == dwell_last);
    nxt       = {1'b0, step} + {1'b0, sh_delta};
    past_stop = nxt[PHASE_W] || (nxt[PHASE_W-1:0] > sh_stop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_mode   <= MODE_FIXED;
      sh_start  <= '0;
      sh_stop   <= '0;
      sh_delta  <= '0;
      sh_dwell  <= '0;
      dwell_cnt <= '0;
      step      <= '0;
    end else begin
      if (load) begin
        sh_mode  <= sanitize_mode(cfg_mode);
        sh_start <= cfg_start;
        sh_stop  <= cfg_stop;
        sh_delta <= cfg_delta;
        sh_dwell <= cfg_dwell;
      end
      // A config accepted on the start edge seeds that burst directly.
      if (init) begin
        step      <= load ? cfg_start : sh_start;
        dwell_cnt <= '0;
      end else if (advance && (sh_mode != MODE_FIXED)) begin
        if (dwell_end) begin
          dwell_cnt <= '0;
          if (past_stop) step <= (sh_mode == MODE_SINGLE) ? sh_stop : sh_start;
          else           step <= nxt[PHASE_W-1:0];
        end else begin
          dwell_cnt <= dwell_cnt + DWELL_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/triangle_sweep_ctrl.sv
// Triangle generator sequencer: burst FSM, phase accumulator, period counter and config handshake.
module triangle_sweep_ctrl
  import triangle_sweep_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned CYC_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_start,
  input  logic [PHASE_W-1:0] cfg_stop,
  input  logic [PHASE_W-1:0] cfg_delta,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [CYC_W-1:0]   cfg_cycles,
  input  logic               start,
  input  logic               stop,
  output logic [PHASE_W-1:0] phase_acc,
  output logic [PHASE_W-1:0] phase_step,
  output logic               wrap,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [CYC_W-1:0]   sh_cycles;
  logic [CYC_W-1:0]   cyc_cnt;

  logic               accept;
  logic               launch;
  logic               running;
  logic [PHASE_W:0]   sum;
  logic               carry;
  logic               last_period;
  logic               terminal;

  always_comb begin
    cfg_ready   = (state == ST_IDLE);
    accept      = cfg_valid && cfg_ready;
    launch      = (state == ST_IDLE) && start;
    running     = (state == ST_RUN) || (state == ST_STOPPING);
    sum         = {1'b0, phase_acc} + {1'b0, phase_step};
    carry       = sum[PHASE_W];
    last_period = (sh_cycles != '0) && (cyc_cnt == sh_cycles - CYC_W'(1));
    terminal    = carry && ((state == ST_STOPPING) || stop || last_period);
  end

  sweep_step_gen #(
    .PHASE_W (PHASE_W),
    .DWELL_W (DWELL_W)
  ) u_step_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .cfg_mode  (cfg_mode),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .cfg_delta (cfg_delta),
    .cfg_dwell (cfg_dwell),
    .init      (launch),
    .advance   (running),
    .step      (phase_step)
  );

  // Burst FSM with registered accumulator and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      sh_cycles <= '0;
      cyc_cnt   <= '0;
      phase_acc <= '0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (accept) sh_cycles <= cfg_cycles;
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            busy      <= 1'b1;
            phase_acc <= '0;
            cyc_cnt   <= '0;
          end
        end
        ST_RUN, ST_STOPPING: begin
          wrap <= carry;
          if (terminal) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            phase_acc <= '0;
          end else begin
            phase_acc <= sum[PHASE_W-1:0];
            // Continuous bursts saturate the period count instead of rolling over.
            if (carry && !((sh_cycles == '0) && (cyc_cnt == '1)))
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            if ((state == ST_RUN) && stop) state <= ST_STOPPING;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_triangle_sweep_ctrl.sv
// Directed bench for triangle_sweep_ctrl: fixed, sweep, stop, handshake and reset scenarios.
module tb_triangle_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [31:0] cfg_start;
  logic [31:0] cfg_stop;
  logic [31:0] cfg_delta;
  logic [15:0] cfg_dwell;
  logic [15:0] cfg_cycles;
  logic        start;
  logic        stop;
  logic [31:0] phase_acc;
  logic [31:0] phase_step;
  logic        wrap;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  triangle_sweep_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_start  (cfg_start),
    .cfg_stop   (cfg_stop),
    .cfg_delta  (cfg_delta),
    .cfg_dwell  (cfg_dwell),
    .cfg_cycles (cfg_cycles),
    .start      (start),
    .stop       (stop),
    .phase_acc  (phase_acc),
    .phase_step (phase_step),
    .wrap       (wrap),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycles_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] m, input logic [31:0] st, input logic [31:0] sp,
                         input logic [31:0] dl, input logic [15:0] dw, input logic [15:0] cy);
    cfg_mode = m; cfg_start = st; cfg_stop = sp; cfg_delta = dl; cfg_dwell = dw; cfg_cycles = cy;
  endtask

  // Accept a config in IDLE, leaving one idle cycle before any start.
  task automatic load_cfg(input logic [1:0] m, input logic [31:0] st, input logic [31:0] sp,
                          input logic [31:0] dl, input logic [15:0] dw, input logic [15:0] cy);
    @(negedge clk);
    set_cfg(m, st, sp, dl, dw, cy);
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Returns at the negedge of RUN cycle 1.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag, input logic [31:0] exp_step);
    chk({tag, ".busy"},  64'(busy), 64'd0);
    chk({tag, ".done"},  64'(done), 64'd0);
    chk({tag, ".wrap"},  64'(wrap), 64'd0);
    chk({tag, ".acc"},   64'(phase_acc), 64'd0);
    chk({tag, ".step"},  64'(phase_step), 64'(exp_step));
    chk({tag, ".ready"}, 64'(cfg_ready), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    cycles_n(2);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cfg_valid = 1'b0; start = 1'b0; stop = 1'b0;
    set_cfg(2'd0, 32'd0, 32'd0, 32'd0, 16'd0, 16'd0);
    cycles_n(2);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("rst", 32'd0);

    // 1: fixed frequency, two periods
    load_cfg(2'd0, 32'h0100_0000, 32'd0, 32'd0, 16'd0, 16'd2);
    pulse_start();
    chk("fix.c1.acc",  64'(phase_acc), 64'd0);
    chk("fix.c1.step", 64'(phase_step), 64'h0100_0000);
    chk("fix.c1.busy", 64'(busy), 64'd1);
    cycles_n(1);
    chk("fix.c2.acc",  64'(phase_acc), 64'h0100_0000);
    cycles_n(254);
    chk("fix.c256.acc",  64'(phase_acc), 64'hFF00_0000);
    chk("fix.c256.wrap", 64'(wrap), 64'd0);
    cycles_n(1);
    chk("fix.c257.acc",  64'(phase_acc), 64'd0);
    chk("fix.c257.wrap", 64'(wrap), 64'd1);
    chk("fix.c257.done", 64'(done), 64'd0);
    cycles_n(1);
    chk("fix.c258.wrap", 64'(wrap), 64'd0);
    chk("fix.c258.acc",  64'(phase_acc), 64'h0100_0000);
    cycles_n(254);
    chk("fix.c512.acc",  64'(phase_acc), 64'hFF00_0000);
    chk("fix.c512.done", 64'(done), 64'd0);
    cycles_n(1);
    chk("fix.c513.done", 64'(done), 64'd1);
    chk("fix.c513.wrap", 64'(wrap), 64'd1);
    chk("fix.c513.acc",  64'(phase_acc), 64'd0);
    chk("fix.c513.busy", 64'(busy), 64'd1);
    cycles_n(1);
    chk_idle("fix.end", 32'h0100_0000);

    // 2: single sweep, holds at stop step
    load_cfg(2'd1, 32'h1000, 32'h4000, 32'h1000, 16'd4, 16'd0);
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      int blk;
      blk = (k - 1) / 4 + 1;
      if (blk > 4) blk = 4;
      chk($sformatf("ss.c%0d.step", k), 64'(phase_step), 64'(32'h1000 * blk));
      cycles_n(1);
    end
    do_reset();

    // 3 + 6: repeating sweep, then async reset mid-sweep
    load_cfg(2'd2, 32'h1000, 32'h4000, 32'h1000, 16'd4, 16'd0);
    pulse_start();
    for (int k = 1; k <= 20; k++) begin
      int blk;
      blk = ((k - 1) / 4) % 4 + 1;
      chk($sformatf("rs.c%0d.step", k), 64'(phase_step), 64'(32'h1000 * blk));
      cycles_n(1);
    end
    chk("rs.c21.step", 64'(phase_step), 64'h2000);
    chk("rs.c21.busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("ar.acc",   64'(phase_acc), 64'd0);
    chk("ar.step",  64'(phase_step), 64'd0);
    chk("ar.busy",  64'(busy), 64'd0);
    chk("ar.ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_idle("ar.idle", 32'd0);
    load_cfg(2'd0, 32'h2000_0000, 32'd0, 32'd0, 16'd0, 16'd1);
    pulse_start();
    chk("ar.c1.step", 64'(phase_step), 64'h2000_0000);
    cycles_n(1);
    chk("ar.c2.acc", 64'(phase_acc), 64'h2000_0000);
    cycles_n(7);
    chk("ar.c9.done", 64'(done), 64'd1);
    cycles_n(1);
    chk_idle("ar.end", 32'h2000_0000);

    // 4 + 5: graceful stop, cfg held off while busy
    load_cfg(2'd0, 32'h4000_0000, 32'd0, 32'd0, 16'd0, 16'd0);
    pulse_start();
    chk("st.c1.acc", 64'(phase_acc), 64'd0);
    stop = 1'b1;
    cycles_n(1);
    stop = 1'b0;
    set_cfg(2'd0, 32'h0000_1234, 32'd0, 32'd0, 16'd0, 16'd5);
    cfg_valid = 1'b1;
    chk("hs.run.ready", 64'(cfg_ready), 64'd0);
    chk("st.c2.acc", 64'(phase_acc), 64'h4000_0000);
    cycles_n(1);
    cfg_valid = 1'b0;
    chk("st.c3.acc", 64'(phase_acc), 64'h8000_0000);
    cycles_n(1);
    chk("st.c4.acc",  64'(phase_acc), 64'hC000_0000);
    chk("st.c4.done", 64'(done), 64'd0);
    cycles_n(1);
    chk("st.c5.done", 64'(done), 64'd1);
    chk("st.c5.wrap", 64'(wrap), 64'd1);
    chk("st.c5.acc",  64'(phase_acc), 64'd0);
    cycles_n(1);
    chk_idle("st.end", 32'h4000_0000);

    // Restart from shadow; stop coinciding with the carry ends the burst directly
    pulse_start();
    chk("hs.shadow.step", 64'(phase_step), 64'h4000_0000);
    cycles_n(3);
    chk("sc.c4.acc", 64'(phase_acc), 64'hC000_0000);
    stop = 1'b1;
    cycles_n(1);
    stop = 1'b0;
    chk("sc.c5.done", 64'(done), 64'd1);
    chk("sc.c5.acc",  64'(phase_acc), 64'd0);
    cycles_n(1);
    chk_idle("sc.end", 32'h4000_0000);

    // Config accept and start on the same edge
    @(negedge clk);
    set_cfg(2'd3, 32'h8000_0000, 32'd0, 32'h1, 16'd1, 16'd1);
    cfg_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    chk("hs.same.step", 64'(phase_step), 64'h8000_0000);
    chk("hs.same.busy", 64'(busy), 64'd1);
    cycles_n(1);
    chk("hs.same.c2.acc",  64'(phase_acc), 64'h8000_0000);
    chk("hs.same.c2.step", 64'(phase_step), 64'h8000_0000);
    cycles_n(1);
    chk("hs.same.c3.done", 64'(done), 64'd1);
    cycles_n(1);
    chk_idle("hs.same.end", 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
